// File: rtl/k_sqrt_pkg.sv
// Shared constants for the half-precision square-root approximator:
// IEEE-754 special encodings, exponent bias and the mantissa table.
package k_sqrt_pkg;

    localparam int          BIAS     = 15;
    localparam logic [15:0] HALF_NAN = 16'h7E00;
    localparam logic [15:0] HALF_INF = 16'h7C00;

    // Row 0: sqrt of the segment midpoint (even exponent); row 1: sqrt of twice it (odd exponent).
    localparam logic [9:0] TABLE [2][16] = '{
        '{10'd16,  10'd47,  10'd77,  10'd106, 10'd135, 10'd163, 10'd190, 10'd217,
          10'd243, 10'd269, 10'd294, 10'd318, 10'd343, 10'd366, 10'd390, 10'd413},
        '{10'd447, 10'd491, 10'd533, 10'd575, 10'd615, 10'd655, 10'd693, 10'd731,
          10'd768, 10'd804, 10'd840, 10'd875, 10'd909, 10'd942, 10'd975, 10'd1008}
    };

    typedef enum logic [1:0] {
        KIND_NORM,
        KIND_ZERO,
        KIND_INF,
        KIND_NAN
    } kind_e;

endpackage

// File: rtl/k_sqrt_classify.sv
// Combinational operand decoder: special-value flags, result exponent,
// exponent parity and the mantissa table index.
module k_sqrt_classify
    import k_sqrt_pkg::*;
#(
    parameter int SEGS = 16
) (
    input  logic [15:0]              operand,
    output logic                     zero,
    output logic                     inf,
    output logic                     nan,
    output logic                     neg,
    output logic                     parity,
    output logic [4:0]               exponent,
    output logic [$clog2(SEGS)-1:0]  index
);

    localparam int IDX_W = $clog2(SEGS);

    logic [4:0]        biased;
    logic              mant_nz;
    logic signed [5:0] e_unb;
    logic signed [5:0] e_half;

    always_comb begin
        biased   = operand[14:10];
        mant_nz  = |operand[9:0];
        zero     = (biased == 5'd0);
        inf      = (biased == 5'd31) && !mant_nz;
        nan      = (biased == 5'd31) && mant_nz;
        neg      = operand[15];
        e_unb    = $signed({1'b0, biased}) - 6'(BIAS);
        // Arithmetic shift gives floor(e/2) for negative exponents too.
        e_half   = e_unb >>> 1;
        exponent = 5'(e_half + 6'(BIAS));
        parity   = e_unb[0];
        index    = operand[9 -: IDX_W];
    end

endmodule

// File: rtl/k_12_sqrt.sv
// Two-stage half-precision approximate square root: stage 1 classifies and
// indexes, stage 2 looks up the mantissa and registers the result.
module k_12_sqrt
    import k_sqrt_pkg::*;
#(
    parameter int SEGS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] out,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int IDX_W = $clog2(SEGS);

    logic             c_zero, c_inf, c_nan, c_neg, c_parity;
    logic [4:0]       c_exp;
    logic [IDX_W-1:0] c_index;
    kind_e            c_kind;

    logic             advance;
    logic             s1_valid;
    kind_e            s1_kind;
    logic             s1_parity;
    logic [4:0]       s1_exp;
    logic [IDX_W-1:0] s1_index;
    logic [9:0]       mant;
    logic [15:0]      result;

    k_sqrt_classify #(.SEGS(SEGS)) u_classify (
        .operand  (in),
        .zero     (c_zero),
        .inf      (c_inf),
        .nan      (c_nan),
        .neg      (c_neg),
        .parity   (c_parity),
        .exponent (c_exp),
        .index    (c_index)
    );

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Zero/subnormal wins over sign so -0 maps to +0; -inf falls into NaN.
    always_comb begin
        c_kind = KIND_NORM;
        if (c_zero)               c_kind = KIND_ZERO;
        else if (c_nan || c_neg)  c_kind = KIND_NAN;
        else if (c_inf)           c_kind = KIND_INF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_kind   <= KIND_ZERO;
            s1_parity <= 1'b0;
            s1_exp    <= '0;
            s1_index  <= '0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            s1_kind   <= c_kind;
            s1_parity <= c_parity;
            s1_exp    <= c_exp;
            s1_index  <= c_index;
        end
    end

    always_comb begin
        mant = '0;
        case ({s1_parity, s1_index})
            5'h00: mant = TABLE[0][0];   5'h01: mant = TABLE[0][1];
            5'h02: mant = TABLE[0][2];   5'h03: mant = TABLE[0][3];
            5'h04: mant = TABLE[0][4];   5'h05: mant = TABLE[0][5];
            5'h06: mant = TABLE[0][6];   5'h07: mant = TABLE[0][7];
            5'h08: mant = TABLE[0][8];   5'h09: mant = TABLE[0][9];
            5'h0A: mant = TABLE[0][10];  5'h0B: mant = TABLE[0][11];
            5'h0C: mant = TABLE[0][12];  5'h0D: mant = TABLE[0][13];
            5'h0E: mant = TABLE[0][14];  5'h0F: mant = TABLE[0][15];
            5'h10: mant = TABLE[1][0];   5'h11: mant = TABLE[1][1];
            5'h12: mant = TABLE[1][2];   5'h13: mant = TABLE[1][3];
            5'h14: mant = TABLE[1][4];   5'h15: mant = TABLE[1][5];
            5'h16: mant = TABLE[1][6];   5'h17: mant = TABLE[1][7];
            5'h18: mant = TABLE[1][8];   5'h19: mant = TABLE[1][9];
            5'h1A: mant = TABLE[1][10];  5'h1B: mant = TABLE[1][11];
            5'h1C: mant = TABLE[1][12];  5'h1D: mant = TABLE[1][13];
            5'h1E: mant = TABLE[1][14];  5'h1F: mant = TABLE[1][15];
            default: mant = '0;
        endcase
    end

    always_comb begin
        result = '0;
        case (s1_kind)
            KIND_NORM: result = {1'b0, s1_exp, mant};
            KIND_ZERO: result = '0;
            KIND_INF:  result = HALF_INF;
            KIND_NAN:  result = HALF_NAN;
            default:   result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out       <= '0;
        end else if (advance) begin
            out_valid <= s1_valid;
            if (s1_valid) out <= result;
        end
    end

endmodule
